// File: rtl/exec_ctrl.sv
// RV32I execute sequencer: decodes one instruction, drives one or two ALU passes,
// and hands a writeback/redirect record to the register file and PC logic.
module exec_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_alu_op_a,
  output logic [31:0] o_alu_op_b,
  input  logic [31:0] i_alu_data,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_br_taken,
  output logic [31:0] o_br_target,
  output logic        o_illegal
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned OPW  = 4;

  localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [OPW-1:0] ALU_SLT  = 4'd2;
  localparam logic [OPW-1:0] ALU_SLTU = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [OPW-1:0] ALU_OR   = 4'd5;
  localparam logic [OPW-1:0] ALU_AND  = 4'd6;
  localparam logic [OPW-1:0] ALU_SLL  = 4'd7;
  localparam logic [OPW-1:0] ALU_SRL  = 4'd8;
  localparam logic [OPW-1:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_WB} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   instr_q, pc_q, rs1_q, rs2_q;
  logic [XLEN-1:0]   instr_d, pc_d, rs1_d, rs2_d;
  logic              cond_q, cond_d;
  logic              instr_ready_d, wb_valid_d, wb_we_d, br_taken_d, illegal_d;
  logic [OPW-1:0]    alu_op_d;
  logic [XLEN-1:0]   alu_a_d, alu_b_d, wb_data_d, br_target_d;
  logic [REGW-1:0]   wb_rd_d;

  logic [XLEN-1:0]   src_instr, src_pc, src_rs1, src_rs2;
  logic [XLEN-1:0]   imm_i, imm_u, imm_b, imm_j;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic [REGW-1:0]   dec_rd;
  logic              alt, dec_illegal, dec_branch, dec_jal, dec_jalr;
  logic [OPW-1:0]    ex1_op;
  logic [XLEN-1:0]   ex1_a, ex1_b, ex2_a, ex2_b;

  function automatic logic [OPW-1:0] alu_map(input logic [2:0] fn3, input logic use_alt);
    case (fn3)
      3'b000:  alu_map = use_alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = use_alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  // Decode the offered word while idle, the latched word afterwards.
  always_comb begin
    src_instr = (state_q == S_IDLE) ? i_instr    : instr_q;
    src_pc    = (state_q == S_IDLE) ? i_pc       : pc_q;
    src_rs1   = (state_q == S_IDLE) ? i_rs1_data : rs1_q;
    src_rs2   = (state_q == S_IDLE) ? i_rs2_data : rs2_q;
    opc    = src_instr[6:0];
    f3     = src_instr[14:12];
    f7     = src_instr[31:25];
    dec_rd = src_instr[11:7];
    alt    = (f7 == F7_ALT);
    imm_i  = {{20{src_instr[31]}}, src_instr[31:20]};
    imm_u  = {src_instr[31:12], 12'b0};
    imm_b  = {{19{src_instr[31]}}, src_instr[31], src_instr[7], src_instr[30:25],
              src_instr[11:8], 1'b0};
    imm_j  = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12], src_instr[20],
              src_instr[30:21], 1'b0};
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    dec_jal     = 1'b0;
    dec_jalr    = 1'b0;
    ex1_op = ALU_ADD;
    ex1_a  = '0;
    ex1_b  = '0;
    ex2_a  = '0;
    ex2_b  = '0;
    case (opc)
      OPC_OP: begin
        dec_illegal = !((f7 == 7'b0) || (alt && (f3 == 3'b000 || f3 == 3'b101)));
        ex1_op = alu_map(f3, alt);
        ex1_a  = src_rs1;
        ex1_b  = src_rs2;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      dec_illegal = (f7 != 7'b0);
        else if (f3 == 3'b101) dec_illegal = !((f7 == 7'b0) || alt);
        ex1_op = alu_map(f3, alt && (f3 == 3'b101));
        ex1_a  = src_rs1;
        ex1_b  = (f3[1:0] == 2'b01) ? XLEN'(src_instr[24:20]) : imm_i;
      end
      OPC_LUI: ex1_b = imm_u;
      OPC_AUIPC: begin
        ex1_a = src_pc;
        ex1_b = imm_u;
      end
      OPC_JAL: begin
        dec_jal = 1'b1;
        ex1_a = src_pc;
        ex1_b = XLEN'(4);
        ex2_a = src_pc;
        ex2_b = imm_j;
      end
      OPC_JALR: begin
        dec_jalr    = 1'b1;
        dec_illegal = (f3 != 3'b000);
        ex1_a = src_pc;
        ex1_b = XLEN'(4);
        ex2_a = src_rs1;
        ex2_b = imm_i;
      end
      OPC_BRANCH: begin
        dec_branch  = 1'b1;
        dec_illegal = (f3[2:1] == 2'b01);
        ex1_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
        ex1_a  = src_rs1;
        ex1_b  = src_rs2;
        ex2_a  = src_pc;
        ex2_b  = imm_b;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      cond_q        <= 1'b0;
      o_instr_ready <= 1'b1;
      o_alu_op      <= ALU_ADD;
      o_alu_op_a    <= '0;
      o_alu_op_b    <= '0;
      o_wb_valid    <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_rd       <= '0;
      o_wb_data     <= '0;
      o_br_taken    <= 1'b0;
      o_br_target   <= '0;
      o_illegal     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      cond_q        <= cond_d;
      o_instr_ready <= instr_ready_d;
      o_alu_op      <= alu_op_d;
      o_alu_op_a    <= alu_a_d;
      o_alu_op_b    <= alu_b_d;
      o_wb_valid    <= wb_valid_d;
      o_wb_we       <= wb_we_d;
      o_wb_rd       <= wb_rd_d;
      o_wb_data     <= wb_data_d;
      o_br_taken    <= br_taken_d;
      o_br_target   <= br_target_d;
      o_illegal     <= illegal_d;
    end
  end

  // Next state; the ALU operand registers present the pass for the following state.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    cond_d        = cond_q;
    instr_ready_d = o_instr_ready;
    alu_op_d      = ALU_ADD;
    alu_a_d       = '0;
    alu_b_d       = '0;
    wb_valid_d    = o_wb_valid;
    wb_we_d       = o_wb_we;
    wb_rd_d       = o_wb_rd;
    wb_data_d     = o_wb_data;
    br_taken_d    = o_br_taken;
    br_target_d   = o_br_target;
    illegal_d     = o_illegal;
    case (state_q)
      S_IDLE: begin
        if (i_instr_valid && o_instr_ready) begin
          instr_d       = i_instr;
          pc_d          = i_pc;
          rs1_d         = i_rs1_data;
          rs2_d         = i_rs2_data;
          instr_ready_d = 1'b0;
          if (dec_illegal) begin
            state_d    = S_WB;
            wb_valid_d = 1'b1;
            illegal_d  = 1'b1;
          end else begin
            state_d  = S_EX1;
            alu_op_d = ex1_op;
            alu_a_d  = ex1_a;
            alu_b_d  = ex1_b;
          end
        end
      end
      S_EX1: begin
        if (dec_branch) begin
          // funct3[0] inverts the sense: BNE/BGE/BGEU
          cond_d = f3[2] ? (i_alu_data[0] ^ f3[0]) : ((i_alu_data == '0) ^ f3[0]);
        end else begin
          wb_we_d   = (dec_rd != '0);
          wb_rd_d   = dec_rd;
          wb_data_d = i_alu_data;
        end
        if (dec_branch || dec_jal || dec_jalr) begin
          state_d = S_EX2;
          alu_a_d = ex2_a;
          alu_b_d = ex2_b;
        end else begin
          state_d    = S_WB;
          wb_valid_d = 1'b1;
        end
      end
      S_EX2: begin
        state_d     = S_WB;
        wb_valid_d  = 1'b1;
        br_taken_d  = dec_branch ? cond_q : 1'b1;
        br_target_d = dec_jalr ? {i_alu_data[31:1], 1'b0} : i_alu_data;
      end
      default: begin
        if (i_wb_ready) begin
          state_d       = S_IDLE;
          instr_ready_d = 1'b1;
          wb_valid_d    = 1'b0;
          wb_we_d       = 1'b0;
          wb_rd_d       = '0;
          wb_data_d     = '0;
          br_taken_d    = 1'b0;
          br_target_d   = '0;
          illegal_d     = 1'b0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed cases plus randomized instructions checked against
// an instruction-level reference model; a behavioural ALU closes the loop.
module tb_exec_ctrl;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, wb_ready;
  logic [31:0] instr, pc, rs1, rs2, alu_data;
  logic        instr_ready, wb_valid, wb_we, br_taken, illegal;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, wb_data, br_target;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  ex1_op, ex2_op;
  logic [31:0] ex1_b, last_data, last_target;
  logic        last_taken, last_we;
  int          last_lat;

  typedef struct {
    logic        ill;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
    int          lat;
  } rec_t;

  always #5 clk = ~clk;

  exec_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .o_alu_op(alu_op), .o_alu_op_a(alu_a), .o_alu_op_b(alu_b), .i_alu_data(alu_data),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_we(wb_we), .o_wb_rd(wb_rd),
    .o_wb_data(wb_data), .o_br_taken(br_taken), .o_br_target(br_target),
    .o_illegal(illegal)
  );

  // Behavioural ALU in front of the sequencer.
  always_comb begin
    case (alu_op)
      4'd0:    alu_data = alu_a + alu_b;
      4'd1:    alu_data = alu_a - alu_b;
      4'd2:    alu_data = 32'($signed(alu_a) < $signed(alu_b));
      4'd3:    alu_data = 32'(alu_a < alu_b);
      4'd4:    alu_data = alu_a ^ alu_b;
      4'd5:    alu_data = alu_a | alu_b;
      4'd6:    alu_data = alu_a & alu_b;
      4'd7:    alu_data = alu_a << alu_b[4:0];
      4'd8:    alu_data = alu_a >> alu_b[4:0];
      4'd9:    alu_data = 32'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_data = '0;
    endcase
  end

  // Architectural result of one instruction.
  function automatic rec_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    rec_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, sh;
    logic [31:0] imm_i, imm_u, imm_b, imm_j, opb;
    logic alt, ok, is_op;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    imm_i = 32'($signed(ins) >>> 20);
    imm_u = ins & 32'hFFFF_F000;
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    alt = (f7 == 7'h20);
    e.ill = 1'b0; e.we = 1'b0; e.rd = '0; e.data = '0;
    e.taken = 1'b0; e.target = '0; e.lat = 2;
    ok = 1'b1;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        is_op = (opc == OPC_OP);
        opb = is_op ? b : imm_i;
        sh  = is_op ? b[4:0] : ins[24:20];
        if (is_op) ok = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
        else if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0) || alt;
        case (f3)
          3'd0: e.data = (is_op && alt) ? a - opb : a + opb;
          3'd1: e.data = a << sh;
          3'd2: e.data = 32'($signed(a) < $signed(opb));
          3'd3: e.data = 32'(a < opb);
          3'd4: e.data = a ^ opb;
          3'd5: e.data = alt ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: e.data = a | opb;
          default: e.data = a & opb;
        endcase
      end
      OPC_LUI:   e.data = imm_u;
      OPC_AUIPC: e.data = p + imm_u;
      OPC_JAL: begin
        e.data = p + 4; e.taken = 1'b1; e.target = p + imm_j; e.lat = 3;
      end
      OPC_JALR: begin
        ok = (f3 == 0);
        e.data = p + 4; e.taken = 1'b1; e.target = (a + imm_i) & ~32'h1; e.lat = 3;
      end
      OPC_BRANCH: begin
        ok = !(f3 == 2 || f3 == 3);
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = ($signed(a) < $signed(b));
          3'd5: e.taken = ($signed(a) >= $signed(b));
          3'd6: e.taken = (a < b);
          default: e.taken = (a >= b);
        endcase
        e.target = p + imm_b; e.lat = 3;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ill = 1'b1; e.data = '0; e.taken = 1'b0; e.target = '0; e.lat = 1;
    end else if (opc != OPC_BRANCH) begin
      e.rd = rd; e.we = (rd != 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t e);
    chk({tag, "_valid"},  32'(wb_valid), 32'd1);
    chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
    chk({tag, "_we"},     32'(wb_we), 32'(e.we));
    chk({tag, "_rd"},     32'(wb_rd), 32'(e.rd));
    chk({tag, "_data"},   wb_data, e.data);
    chk({tag, "_taken"},  32'(br_taken), 32'(e.taken));
    chk({tag, "_target"}, br_target, e.target);
  endtask

  // One instruction end to end; hold = cycles of wb_ready low once the record is up.
  task automatic run(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                     input logic [31:0] b, input int hold);
    rec_t e;
    int lat;
    e = model(ins, p, a, b);
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr = ins; pc = p; rs1 = a; rs2 = b;
    instr_valid = 1'b1;
    wb_ready = (hold == 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = $urandom; pc = $urandom; rs1 = $urandom; rs2 = $urandom;
    ex1_op = alu_op; ex1_b = alu_b; ex2_op = 4'hF;
    lat = 1;
    while (!wb_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) ex2_op = alu_op;
    end
    last_lat = lat; last_data = wb_data; last_target = br_target;
    last_taken = br_taken; last_we = wb_we;
    chk("latency", 32'(lat), 32'(e.lat));
    chk_rec("rec", e);
    for (int i = 0; i < hold; i++) begin
      chk("ready_busy", 32'(instr_ready), 32'd0);
      @(posedge clk); #1;
      chk_rec("held", e);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(wb_valid), 32'd0);
    chk("ready_back", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; wb_ready = 1'b1;
    instr = '0; pc = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_target", br_target, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD x3,x1,x2
    run({7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP}, 32'h40, 32'd5, 32'd7, 0);
    chk("add_ex1_op", 32'(ex1_op), 32'd0);
    chk("add_lat", 32'(last_lat), 32'd2);
    chk("add_data", last_data, 32'd12);

    // SRAI x4,x1,4
    run({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd4, OPC_OPIMM}, 32'h44, 32'h8000_0000, 32'd0, 0);
    chk("srai_ex1_op", 32'(ex1_op), 32'd9);
    chk("srai_ex1_b", ex1_b, 32'd4);
    chk("srai_data", last_data, 32'hF800_0000);

    // BEQ x1,x2,+16 taken then not taken
    run({1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, OPC_BRANCH}, 32'h100, 32'd9, 32'd9, 1);
    chk("beq_ex1_op", 32'(ex1_op), 32'd1);
    chk("beq_ex2_op", 32'(ex2_op), 32'd0);
    chk("beq_lat", 32'(last_lat), 32'd3);
    chk("beq_taken", 32'(last_taken), 32'd1);
    chk("beq_target", last_target, 32'h110);
    chk("beq_we", 32'(last_we), 32'd0);
    run({1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, OPC_BRANCH}, 32'h100, 32'd9, 32'd8, 0);
    chk("bne_path_taken", 32'(last_taken), 32'd0);

    // JALR x1,x2,3
    run({12'd3, 5'd2, 3'b000, 5'd1, OPC_JALR}, 32'h200, 32'h1000, 32'd0, 0);
    chk("jalr_data", last_data, 32'h204);
    chk("jalr_target", last_target, 32'h1002);
    chk("jalr_taken", 32'(last_taken), 32'd1);

    // Load opcode: illegal, held under backpressure
    run({20'h0, 5'd5, 7'b0000011}, 32'h300, 32'd1, 32'd2, 5);
    chk("load_lat", 32'(last_lat), 32'd1);
    chk("load_we", 32'(last_we), 32'd0);

    // Wrap-around of pc+4 and pc+imm
    run({1'b0, 10'd8, 1'b0, 8'd0, 5'd6, OPC_JAL}, 32'hFFFF_FFFC, 32'd0, 32'd0, 0);
    chk("wrap_data", last_data, 32'd0);
    chk("wrap_target", last_target, 32'd12);

    // Reset during EX2 of a JAL drops the instruction
    instr = {1'b0, 10'd8, 1'b0, 8'd0, 5'd1, OPC_JAL}; pc = 32'h500; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_taken", 32'(br_taken), 32'd0);
    chk("mid_rst_target", br_target, 32'd0);
    chk("mid_rst_data", wb_data, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_discard", 32'(wb_valid), 32'd0);

    // Randomized instruction mix
    for (int n = 0; n < 120; n++) begin
      logic [31:0] ins, a, b;
      int k;
      ins = $urandom;
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1: ins[6:0] = OPC_OP;
        2, 3: ins[6:0] = OPC_OPIMM;
        4: ins[6:0] = OPC_LUI;
        5: ins[6:0] = OPC_AUIPC;
        6: ins[6:0] = OPC_JAL;
        7: ins[6:0] = OPC_JALR;
        8: ins[6:0] = OPC_BRANCH;
        default: ;
      endcase
      if (k <= 3) begin
        case ($urandom_range(0, 3))
          0, 1: ins[31:25] = 7'h00;
          2: ins[31:25] = 7'h20;
          default: ;
        endcase
      end
      if (k == 7 && $urandom_range(0, 3) != 0) ins[14:12] = 3'b000;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run(ins, $urandom, a, b, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
